// File: rtl/uart_pkg.sv
// uart_pkg: shared assembler state codes, count width and byte-slot mapping.
package uart_pkg;
  localparam logic ASM_IDLE    = 1'b0;
  localparam logic ASM_COLLECT = 1'b1;
  localparam int MAX_BYTES = 8;
  // Sized for the largest supported word so every NUM_BYTES in 2..8 fits.
  localparam int CNT_W = $clog2(MAX_BYTES);
  function automatic int slot_idx(input int k, input int num_bytes, input bit msb_first);
    return msb_first ? num_bytes - 1 - k : k;
  endfunction
endpackage

// File: rtl/word_hold_reg.sv
// word_hold_reg: output holding register with ready/valid drain and dropped-word detect.
module word_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         out_ready,
  input  logic         ovf_clr,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         overflow
);
  logic take;
  assign take = load && (!out_valid || out_ready);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out       <= take ? word : out;
      out_valid <= take || (out_valid && !out_ready);
      overflow  <= (load && !take) || (overflow && !ovf_clr);
    end
endmodule

// File: rtl/word_assembler.sv
// word_assembler: packs NUM_BYTES received bytes into a registered ready/valid word.
// Optional partial-word idle timeout is built only when ASM_TIMEOUT_EN is defined.
module word_assembler
  import uart_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [BYTE_W-1:0]           data_in,
  input  logic                        valid,
  output logic [BYTE_W*NUM_BYTES-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        timeout_err
);
  localparam int W = BYTE_W * NUM_BYTES;
  if (NUM_BYTES < 2 || NUM_BYTES > MAX_BYTES || TIMEOUT < 2) begin : g_bad_cfg
    $error("word_assembler: unsupported parameter set");
  end
  logic             state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     acc, acc_nxt, byte_sh;
  logic             last, expire;
  assign last = valid && cnt == CNT_W'(NUM_BYTES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ASM_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  always_comb begin
    state_nxt = valid ? (last ? ASM_IDLE : ASM_COLLECT) : (expire ? ASM_IDLE : state);
    cnt_nxt   = valid ? (last ? '0 : cnt + CNT_W'(1)) : (expire ? '0 : cnt);
  end
  // A word that starts from IDLE begins from zero so unfilled slots read 0.
  always_comb begin
    byte_sh = {{(W - BYTE_W){1'b0}}, data_in} << (BYTE_W * slot_idx(int'(cnt), NUM_BYTES, MSB_FIRST != 0));
    acc_nxt = valid ? ((state == ASM_IDLE ? '0 : acc) | byte_sh) : acc;
  end
  word_hold_reg #(.W(W)) u_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (last),
    .word     (acc_nxt),
    .out_ready(out_ready),
    .ovf_clr  (ovf_clr),
    .out      (out),
    .out_valid(out_valid),
    .overflow (overflow)
  );
`ifdef ASM_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT);
  logic [IW-1:0] idle;
  // A byte on the expiry cycle wins: expire needs valid low.
  assign expire = state == ASM_COLLECT && !valid && idle == IW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idle        <= '0;
      timeout_err <= 1'b0;
    end else begin
      idle        <= (valid || state == ASM_IDLE || expire) ? '0 : idle + IW'(1);
      timeout_err <= expire;
    end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_word_assembler.sv
// tb_word_assembler: vector table, corner sequences and randomized model check.
module tb_word_assembler;
  localparam int TO = 16;
  localparam int NB = 2;
`ifdef ASM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] data_in = '0, data1 = '0;
  logic valid = 1'b0, valid1 = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0, out_ready1 = 1'b1, ovf_clr1 = 1'b0;
  logic [15:0] out;
  logic out_valid, overflow, timeout_err;
  logic [31:0] out1;
  logic out_valid1, overflow1, timeout_err1;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  word_assembler #(.BYTE_W(8), .NUM_BYTES(NB), .MSB_FIRST(1), .TIMEOUT(TO)) u0 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid(valid), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .ovf_clr(ovf_clr), .timeout_err(timeout_err));
  word_assembler #(.BYTE_W(8), .NUM_BYTES(4), .MSB_FIRST(0), .TIMEOUT(TO)) u1 (
    .clk(clk), .reset_n(reset_n), .data_in(data1), .valid(valid1), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .overflow(overflow1), .ovf_clr(ovf_clr1), .timeout_err(timeout_err1));
  typedef struct {
    logic [7:0]  d;
    logic        v, r, c;
    logic [15:0] eo;
    logic        ev, eovf;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic v, input logic r, input logic c);
    data_in = d; valid = v; out_ready = r; ovf_clr = c; valid1 = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic step1(input logic [7:0] d);
    data1 = d; valid1 = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    valid1 = 1'b0;
  endtask
  logic [7:0] bq[$];
  logic [15:0] m_out, w;
  logic m_valid, m_ovf, m_te, load, r, v, c;
  logic [7:0] d;
  int gap, pulses, at;
  initial begin
    #400;
    chk("reset out", out, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset overflow", overflow, 0);
    chk("reset timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    tbl.push_back('{8'h4D, 1, 1, 0, 16'h0000, 0, 0});
    tbl.push_back('{8'hE3, 1, 1, 0, 16'h4DE3, 1, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 16'h4DE3, 0, 0});
    tbl.push_back('{8'hFF, 1, 0, 0, 16'h4DE3, 0, 0});
    tbl.push_back('{8'h00, 1, 0, 0, 16'hFF00, 1, 0});
    tbl.push_back('{8'hA5, 1, 0, 0, 16'hFF00, 1, 0});
    tbl.push_back('{8'h5A, 1, 0, 0, 16'hFF00, 1, 1});
    tbl.push_back('{8'h00, 0, 0, 1, 16'hFF00, 1, 0});
    tbl.push_back('{8'h12, 1, 0, 0, 16'hFF00, 1, 0});
    tbl.push_back('{8'h34, 1, 1, 0, 16'h1234, 1, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 16'h1234, 0, 0});
    tbl.push_back('{8'hAA, 1, 0, 0, 16'h1234, 0, 0});
    tbl.push_back('{8'hBB, 1, 0, 0, 16'hAABB, 1, 0});
    tbl.push_back('{8'hCC, 1, 0, 0, 16'hAABB, 1, 0});
    tbl.push_back('{8'hDD, 1, 0, 1, 16'hAABB, 1, 1});
    tbl.push_back('{8'h00, 0, 0, 1, 16'hAABB, 1, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 16'hAABB, 0, 0});
    tbl.push_back('{8'h11, 1, 1, 0, 16'hAABB, 0, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 16'hAABB, 0, 0});
    tbl.push_back('{8'h22, 1, 1, 0, 16'h1122, 1, 0});
    tbl.push_back('{8'h00, 0, 1, 0, 16'h1122, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl[%0d] out", i), out, tbl[i].eo);
      chk($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl[%0d] overflow", i), overflow, tbl[i].eovf);
      chk($sformatf("tbl[%0d] timeout_err", i), timeout_err, 0);
    end
    step1(8'h11); step1(8'h22); step1(8'h33);
    chk("lsb4 early valid", out_valid1, 0);
    step1(8'h44);
    chk("lsb4 out", out1, 32'h44332211);
    chk("lsb4 out_valid", out_valid1, 1);
    step(8'hAB, 1, 1, 0);
    reset_n = 1'b0;
    #1;
    chk("midreset out", out, 0);
    chk("midreset out_valid", out_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(8'hCD, 1, 1, 0);
    chk("midreset partial", out_valid, 0);
    step(8'hEF, 1, 1, 0);
    chk("midreset word", out, 16'hCDEF);
    chk("midreset word valid", out_valid, 1);
    chk("midreset overflow", overflow, 0);
    chk("midreset timeout_err", timeout_err, 0);
`ifdef ASM_TIMEOUT_EN
    step(8'h77, 1, 1, 0);
    pulses = 0; at = -1;
    for (int i = 0; i < 20; i++) begin
      step(8'h00, 0, 1, 0);
      if (timeout_err) begin pulses++; at = i; end
    end
    chk("timeout pulses", pulses, 1);
    chk("timeout pulse cycle", at, 15);
    step(8'h01, 1, 1, 0);
    step(8'h02, 1, 1, 0);
    chk("after timeout word", out, 16'h0102);
    step(8'h77, 1, 1, 0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin step(8'h00, 0, 1, 0); pulses += int'(timeout_err); end
    step(8'h88, 1, 1, 0);
    chk("late byte word", out, 16'h7788);
    chk("late byte valid", out_valid, 1);
    for (int i = 0; i < 20; i++) begin step(8'h00, 0, 1, 0); pulses += int'(timeout_err); end
    chk("late byte pulses", pulses, 0);
`endif
    reset_n = 1'b0;
    step(8'h00, 0, 1, 0);
    reset_n = 1'b1;
    m_out = '0; m_valid = 0; m_ovf = 0; gap = 0; bq.delete();
    for (int n = 0; n < 400; n++) begin
      d = 8'($urandom); v = $urandom_range(0, 3) != 0; r = $urandom_range(0, 1) == 1; c = $urandom_range(0, 7) == 0;
      load = 0; m_te = 0; w = '0;
      if (v) begin
        bq.push_back(d); gap = 0;
        if (bq.size() == NB) begin
          foreach (bq[k]) w |= 16'(bq[k]) << (8 * (NB - 1 - k));
          load = 1; bq.delete();
        end
      end else if (bq.size() > 0) begin
        gap++;
        if (TO_EN && gap == TO) begin bq.delete(); m_te = 1; end
      end
      if (load && m_valid && !r) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (load && (!m_valid || r)) begin m_out = w; m_valid = 1; end
      else if (r) m_valid = 0;
      step(d, v, r, c);
      chk($sformatf("rnd[%0d] out", n), out, m_out);
      chk($sformatf("rnd[%0d] out_valid", n), out_valid, m_valid);
      chk($sformatf("rnd[%0d] overflow", n), overflow, m_ovf);
      chk($sformatf("rnd[%0d] timeout_err", n), timeout_err, m_te);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
